// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one-outstanding imem requests
// and buffers returned words ahead of the decode/control consumer.
module instr_fetch_unit #(
   parameter int unsigned     PC_W     = 6,
   parameter int unsigned     INSTR_W  = 16,
   parameter int unsigned     DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_en,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [3:0]         dec_opcode,
   output logic [3:0]         dec_rd,
   output logic [3:0]         dec_rs,
   output logic [3:0]         dec_rt,
   output logic [PC_W-1:0]    dec_pc,
   output logic [PC_W-1:0]    dec_pc_plus1
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DISCARD
   } state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]      count_q;
   logic [INSTR_W-1:0] buf_instr_q [DEPTH];
   logic [PC_W-1:0]    buf_pc_q [DEPTH];
   logic               push, pop;
   logic [CW-1:0]      cnt_pop, cnt_push_pop;

   assign dec_valid    = (count_q != '0);
   assign pop          = dec_valid && dec_ready;
   assign cnt_pop      = count_q - CW'(pop);
   assign cnt_push_pop = cnt_pop + CW'(1);

   assign imem_req  = (state_q != IDLE);
   assign imem_addr = (state_q == DISCARD) ? hold_pc_q : fetch_pc_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      hold_pc_d  = hold_pc_q;
      push       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fetch_en && (redirect || cnt_pop < FULL))
               state_d = FETCH;
         end
         FETCH: begin
            if (redirect) begin
               if (imem_ack) begin
                  state_d = fetch_en ? FETCH : IDLE;
               end else begin
                  state_d   = DISCARD;
                  hold_pc_d = fetch_pc_q;
               end
            end else if (imem_ack) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + PC_W'(1);
               if (fetch_en && cnt_push_pop < FULL)
                  state_d = FETCH;
               else
                  state_d = IDLE;
            end
         end
         DISCARD: begin
            if (imem_ack)
               state_d = fetch_en ? FETCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (redirect)
         fetch_pc_d = redirect_pc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         hold_pc_q  <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         hold_pc_q  <= hold_pc_d;
      end
   end

   // A flush also discards whatever the consumer popped this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (redirect) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr_q[wr_ptr_q] <= imem_data;
         buf_pc_q[wr_ptr_q]    <= fetch_pc_q;
      end
   end

   assign dec_instr    = dec_valid ? buf_instr_q[rd_ptr_q] : '0;
   assign dec_pc       = dec_valid ? buf_pc_q[rd_ptr_q] : '0;
   assign dec_pc_plus1 = dec_pc + PC_W'(1);
   assign dec_opcode   = dec_instr[15:12];
   assign dec_rd       = dec_instr[11:8];
   assign dec_rs       = dec_instr[7:4];
   assign dec_rt       = dec_instr[3:0];

endmodule
